alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 25 ++
 rtl/alu_decoder.sv | 77 +++++++
 rtl/alu_issue_stage.sv | 66 ++++++
 3 files changed

// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: ALU operation codes and RV32I opcodes shared by the decoder, issue stage and ALU.
package alu_issue_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b1000,
    ALU_SLL     = 4'b0001,
    ALU_SLT     = 4'b0010,
    ALU_SLTU    = 4'b0011,
    ALU_XOR     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SRA     = 4'b1101,
    ALU_OR      = 4'b0110,
    ALU_AND     = 4'b0111,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational RV32I decode into ALU operation, operands and destination register.
module alu_decoder import alu_issue_stage_pkg::*; #(
  parameter logic [3:0] ILLEGAL_OP   = ALU_ILLEGAL,
  parameter logic [3:0] BRANCH_OP_EQ = ALU_SUB
) (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [3:0]  op,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [4:0]  rd,
  output logic        illegal
);
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] dst;
  logic [31:0] imm_i, imm_s, imm_u;
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign dst = instr[11:7];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};
  always_comb begin
    op = ILLEGAL_OP;
    op1 = '0;
    op2 = '0;
    rd = '0;
    illegal = 1'b1;
    case (instr[6:0])
      OPC_OP: if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
        op = {funct7[5], funct3};
        op1 = rs1;
        op2 = rs2;
        rd = dst;
        illegal = 1'b0;
      end
      OPC_OP_IMM: begin
        op = (funct3 == 3'b101 && funct7[5]) ? ALU_SRA : {1'b0, funct3};
        op1 = rs1;
        op2 = funct3[1:0] == 2'b01 ? {27'b0, instr[24:20]} : imm_i;
        rd = dst;
        illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        op = ALU_ADD;
        op1 = instr[5] ? '0 : pc;
        op2 = imm_u;
        rd = dst;
        illegal = 1'b0;
      end
      OPC_LOAD, OPC_STORE: begin
        op = ALU_ADD;
        op1 = rs1;
        op2 = instr[5] ? imm_s : imm_i;
        rd = instr[5] ? '0 : dst;
        illegal = 1'b0;
      end
      OPC_BRANCH: if (funct3[2:1] != 2'b01) begin
        op = !funct3[2] ? BRANCH_OP_EQ : funct3[1] ? ALU_SLTU : ALU_SLT;
        op1 = rs1;
        op2 = rs2;
        illegal = 1'b0;
      end
      OPC_JAL, OPC_JALR: begin
        op = ALU_ADD;
        op1 = pc;
        op2 = 32'd4;
        rd = dst;
        illegal = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an RV32I instruction and holds the ALU operation in a one-entry
// register slice with valid/ready handshake, flush and synchronous reset.
module alu_issue_stage import alu_issue_stage_pkg::*; #(
  parameter logic [3:0] ILLEGAL_OP   = ALU_ILLEGAL,
  parameter logic [3:0] BRANCH_OP_EQ = ALU_SUB
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  output logic [3:0]  alu_operation_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e state, state_nxt;
  logic [3:0] dec_op;
  logic [31:0] dec_op1, dec_op2;
  logic [4:0] dec_rd;
  logic dec_illegal, accept;
  alu_decoder #(.ILLEGAL_OP(ILLEGAL_OP), .BRANCH_OP_EQ(BRANCH_OP_EQ)) u_dec (
    .instr(instr_i),
    .pc(pc_i),
    .rs1(rs1_data_i),
    .rs2(rs2_data_i),
    .op(dec_op),
    .op1(dec_op1),
    .op2(dec_op2),
    .rd(dec_rd),
    .illegal(dec_illegal)
  );
  assign out_valid_o = state == FULL;
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept = in_valid_i && in_ready_o && !flush_i;
  always_comb begin
    state_nxt = flush_i ? EMPTY : (accept || (out_valid_o && !out_ready_i)) ? FULL : EMPTY;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
      alu_operation_o <= '0;
      alu_op1_o <= '0;
      alu_op2_o <= '0;
      rd_o <= '0;
      illegal_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_operation_o <= dec_op;
        alu_op1_o <= dec_op1;
        alu_op2_o <= dec_op2;
        rd_o <= dec_rd;
        illegal_o <= dec_illegal;
      end
    end
  end
endmodule
